// File: rtl/spw_tx_scheduler.sv
// spw_tx_scheduler: per-slot character selection (Time-Code > FCT > N-Char > NULL) and flow-control credit accounting.
// Rev 1.0. Optional macro SPW_TX_STATS_EN adds saturating sent-character counters (statNChar/statFCT/statTC).
`default_nettype none

module spw_tx_scheduler #(
   parameter int MAX_CREDIT = 56,
   parameter int FCT_STEP   = 8,
   parameter int RXBUF_AW   = 6
) (
   input  logic                CLOCK,
   input  logic                RESETn,
   input  logic                resetTx,
   input  logic                enableTx,
   input  logic                sendNULLs,
   input  logic                sendFCTs,
   input  logic                sendNChars,
   input  logic                sendTimeCodes,
   input  logic                gotFCT,
   input  logic                gotNChar,
   input  logic [RXBUF_AW-1:0] rxFree,
   input  logic                TICK_IN,
   input  logic [7:0]          TIME_IN,
   input  logic                TXWRITE,
   input  logic [8:0]          TXDATA,
   output logic                TXRDY,
   input  logic                encAck,
   output logic                charValid,
   output logic [1:0]          charType,
   output logic [8:0]          charData,
   output logic [5:0]          txCredit,
   output logic [5:0]          rxOutstanding,
`ifdef SPW_TX_STATS_EN
   output logic [15:0]         statNChar,
   output logic [15:0]         statFCT,
   output logic [15:0]         statTC,
`endif
   output logic                creditError
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SELECT  = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   localparam logic [1:0] T_NULL  = 2'b00;
   localparam logic [1:0] T_FCT   = 2'b01;
   localparam logic [1:0] T_NCHAR = 2'b10;
   localparam logic [1:0] T_TC    = 2'b11;
   localparam int         SW      = ((RXBUF_AW > 6) ? RXBUF_AW : 6) + 1;

   state_t      state_q;
   logic        charValid_q;
   logic [1:0]  charType_q;
   logic [8:0]  charData_q;
   logic [5:0]  txCredit_q, txCredit_d;
   logic [5:0]  rxOut_q, rxOut_d;
   logic        creditError_q, creditError_d;
   logic        tickPending_q;
   logic [7:0]  tickTime_q;
   logic        holdValid_q;
   logic [8:0]  holdData_q;

   logic          w_clr;
   logic          w_ack;
   logic          w_ack_fct;
   logic          w_ack_nch;
   logic          w_sel_tc;
   logic          w_sel_fct;
   logic          w_sel_nch;
   logic [SW-1:0] w_rx_after_fct;
   logic [6:0]    w_tx_sum;
   logic          w_tx_ovf;
   logic          w_rx_und;

   // enableTx low clears like resetTx, except the Time-Code request survives it
   assign w_clr     = !resetTx || !enableTx;
   assign w_ack     = (state_q == S_PRESENT) && encAck;
   assign w_ack_fct = w_ack && (charType_q == T_FCT);
   assign w_ack_nch = w_ack && (charType_q == T_NCHAR);

   assign w_rx_after_fct = SW'(rxOut_q) + SW'(FCT_STEP);
   assign w_sel_tc  = sendTimeCodes && tickPending_q;
   assign w_sel_fct = sendFCTs && (w_rx_after_fct <= SW'(MAX_CREDIT))
                      && (SW'(rxFree) >= w_rx_after_fct);
   assign w_sel_nch = sendNChars && holdValid_q && (txCredit_q != 6'd0);

   always_comb begin
      w_tx_sum   = 7'(txCredit_q) + (gotFCT ? 7'(FCT_STEP) : 7'd0) - (w_ack_nch ? 7'd1 : 7'd0);
      w_tx_ovf   = gotFCT && (w_tx_sum > 7'(MAX_CREDIT));
      // an overflowing FCT is discarded, but a character actually sent still consumes its credit
      txCredit_d = w_tx_ovf ? (txCredit_q - (w_ack_nch ? 6'd1 : 6'd0)) : w_tx_sum[5:0];
      w_rx_und   = 1'b0;
      rxOut_d    = rxOut_q;
      case ({gotNChar, w_ack_fct})
         2'b11:   rxOut_d = rxOut_q + 6'(FCT_STEP - 1);
         2'b10: begin
            if (rxOut_q == 6'd0) w_rx_und = 1'b1;
            else                 rxOut_d  = rxOut_q - 6'd1;
         end
         2'b01:   rxOut_d = rxOut_q + 6'(FCT_STEP);
         default: rxOut_d = rxOut_q;
      endcase
      creditError_d = w_tx_ovf || w_rx_und;
   end

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q       <= S_IDLE;
         charValid_q   <= 1'b0;
         charType_q    <= T_NULL;
         charData_q    <= '0;
         txCredit_q    <= '0;
         rxOut_q       <= '0;
         creditError_q <= 1'b0;
         tickPending_q <= 1'b0;
         tickTime_q    <= '0;
         holdValid_q   <= 1'b0;
         holdData_q    <= '0;
      end else if (w_clr) begin
         state_q       <= S_IDLE;
         charValid_q   <= 1'b0;
         charType_q    <= T_NULL;
         charData_q    <= '0;
         txCredit_q    <= '0;
         rxOut_q       <= '0;
         creditError_q <= 1'b0;
         holdValid_q   <= 1'b0;
         holdData_q    <= '0;
         if (!resetTx) begin
            tickPending_q <= 1'b0;
            tickTime_q    <= '0;
         end else if (TICK_IN) begin
            tickPending_q <= 1'b1;
            tickTime_q    <= TIME_IN;
         end
      end else begin
         txCredit_q    <= txCredit_d;
         rxOut_q       <= rxOut_d;
         creditError_q <= creditError_d;

         if (TXWRITE && !holdValid_q) begin
            holdValid_q <= 1'b1;
            holdData_q  <= TXDATA;
         end else if (w_ack_nch) begin
            holdValid_q <= 1'b0;
         end

         // a fresh tick in the selecting cycle stays pending for the next slot
         if (TICK_IN) begin
            tickPending_q <= 1'b1;
            tickTime_q    <= TIME_IN;
         end else if ((state_q == S_SELECT) && w_sel_tc) begin
            tickPending_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               charValid_q <= 1'b0;
               state_q     <= S_SELECT;
            end
            S_SELECT: begin
               state_q     <= S_PRESENT;
               charValid_q <= 1'b1;
               if (w_sel_tc) begin
                  charType_q <= T_TC;
                  charData_q <= {1'b0, tickTime_q};
               end else if (w_sel_fct) begin
                  charType_q <= T_FCT;
                  charData_q <= '0;
               end else if (w_sel_nch) begin
                  charType_q <= T_NCHAR;
                  charData_q <= holdData_q;
               end else if (sendNULLs) begin
                  charType_q <= T_NULL;
                  charData_q <= '0;
               end else begin
                  state_q     <= S_SELECT;
                  charValid_q <= 1'b0;
               end
            end
            S_PRESENT: begin
               if (encAck) begin
                  charValid_q <= 1'b0;
                  state_q     <= S_SELECT;
               end
            end
            default: begin
               charValid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SPW_TX_STATS_EN
   logic [15:0] statNChar_q, statFCT_q, statTC_q;

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         statNChar_q <= '0;
         statFCT_q   <= '0;
         statTC_q    <= '0;
      end else if (w_ack) begin
         case (charType_q)
            T_NCHAR: if (statNChar_q != 16'hFFFF) statNChar_q <= statNChar_q + 16'd1;
            T_FCT:   if (statFCT_q   != 16'hFFFF) statFCT_q   <= statFCT_q   + 16'd1;
            T_TC:    if (statTC_q    != 16'hFFFF) statTC_q    <= statTC_q    + 16'd1;
            default: statTC_q <= statTC_q;
         endcase
      end
   end

   assign statNChar = statNChar_q;
   assign statFCT   = statFCT_q;
   assign statTC    = statTC_q;
`endif

   assign TXRDY         = !holdValid_q;
   assign charValid     = charValid_q;
   assign charType      = charType_q;
   assign charData      = charData_q;
   assign txCredit      = txCredit_q;
   assign rxOutstanding = rxOut_q;
   assign creditError   = creditError_q;

endmodule

`default_nettype wire

// File: tb/tb_spw_tx_scheduler.sv
// tb_spw_tx_scheduler: credit-arithmetic vector table plus scoreboarded character-slot sequences.
`default_nettype none

module tb_spw_tx_scheduler;

   localparam logic [1:0] T_NULL  = 2'b00;
   localparam logic [1:0] T_FCT   = 2'b01;
   localparam logic [1:0] T_NCHAR = 2'b10;
   localparam logic [1:0] T_TC    = 2'b11;

   logic       CLOCK, RESETn, resetTx, enableTx;
   logic       sendNULLs, sendFCTs, sendNChars, sendTimeCodes;
   logic       gotFCT, gotNChar, TICK_IN, TXWRITE, encAck;
   logic [5:0] rxFree;
   logic [7:0] TIME_IN;
   logic [8:0] TXDATA;
   logic       TXRDY, charValid, creditError;
   logic [1:0] charType;
   logic [8:0] charData;
   logic [5:0] txCredit, rxOutstanding;
`ifdef SPW_TX_STATS_EN
   logic [15:0] statNChar, statFCT, statTC;
`endif

   spw_tx_scheduler #(.MAX_CREDIT(56), .FCT_STEP(8), .RXBUF_AW(6)) dut (
      .CLOCK(CLOCK), .RESETn(RESETn), .resetTx(resetTx), .enableTx(enableTx),
      .sendNULLs(sendNULLs), .sendFCTs(sendFCTs), .sendNChars(sendNChars),
      .sendTimeCodes(sendTimeCodes), .gotFCT(gotFCT), .gotNChar(gotNChar),
      .rxFree(rxFree), .TICK_IN(TICK_IN), .TIME_IN(TIME_IN), .TXWRITE(TXWRITE),
      .TXDATA(TXDATA), .TXRDY(TXRDY), .encAck(encAck), .charValid(charValid),
      .charType(charType), .charData(charData), .txCredit(txCredit),
      .rxOutstanding(rxOutstanding),
`ifdef SPW_TX_STATS_EN
      .statNChar(statNChar), .statFCT(statFCT), .statTC(statTC),
`endif
      .creditError(creditError)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct packed {
      logic [1:0] t;
      logic [8:0] d;
   } exp_t;

   typedef struct {
      logic       gfct;
      logic       gnch;
      logic [5:0] tx;
      logic [5:0] rx;
      logic       err;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[13];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] t, input logic [8:0] d);
      exp_t e;
      e.t = t;
      e.d = d;
      sb_q.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         @(negedge CLOCK);
         n++;
      end while (!charValid && n < 40);
      chk({name, "_valid"}, charValid, 1);
   endtask

   // wait for a presented character, compare it against the scoreboard head, then acknowledge it
   task automatic serve_slot(input string name);
      exp_t e;
      wait_valid(name);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_sb_empty: got charType 0x%0h, expected none queued", name, charType);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_type"}, charType, e.t);
         if (e.t == T_NCHAR || e.t == T_TC) chk({name, "_data"}, charData, e.d);
      end
      @(posedge CLOCK); #1 encAck = 1'b1;
      @(posedge CLOCK); #1 encAck = 1'b0;
   endtask

   task automatic reset_tx();
      resetTx = 1'b0;
      @(posedge CLOCK); #1 resetTx = 1'b1;
   endtask

   task automatic do_gotfct();
      gotFCT = 1'b1;
      @(posedge CLOCK); #1 gotFCT = 1'b0;
   endtask

   task automatic do_gotnchar(input int n);
      gotNChar = 1'b1;
      repeat (n) @(posedge CLOCK);
      #1 gotNChar = 1'b0;
   endtask

   task automatic do_tick(input logic [7:0] v);
      TIME_IN = v;
      TICK_IN = 1'b1;
      @(posedge CLOCK); #1 TICK_IN = 1'b0;
   endtask

   task automatic do_write(input logic [8:0] d);
      TXDATA  = d;
      TXWRITE = 1'b1;
      @(posedge CLOCK); #1 TXWRITE = 1'b0;
   endtask

   task automatic set_vec(input int i, input logic f, input logic n, input logic [5:0] tx,
                          input logic [5:0] rx, input logic err);
      vt[i].gfct = f; vt[i].gnch = n; vt[i].tx = tx; vt[i].rx = rx; vt[i].err = err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      set_vec(0,  0, 1, 6'd0,  6'd0, 1);
      set_vec(1,  0, 0, 6'd0,  6'd0, 0);
      set_vec(2,  1, 0, 6'd8,  6'd0, 0);
      set_vec(3,  1, 0, 6'd16, 6'd0, 0);
      set_vec(4,  1, 0, 6'd24, 6'd0, 0);
      set_vec(5,  1, 0, 6'd32, 6'd0, 0);
      set_vec(6,  1, 0, 6'd40, 6'd0, 0);
      set_vec(7,  1, 0, 6'd48, 6'd0, 0);
      set_vec(8,  1, 0, 6'd56, 6'd0, 0);
      set_vec(9,  1, 0, 6'd56, 6'd0, 1);
      set_vec(10, 0, 0, 6'd56, 6'd0, 0);
      set_vec(11, 1, 1, 6'd56, 6'd0, 1);
      set_vec(12, 0, 0, 6'd56, 6'd0, 0);

      CLOCK = 0; RESETn = 0; resetTx = 1; enableTx = 0;
      sendNULLs = 0; sendFCTs = 0; sendNChars = 0; sendTimeCodes = 0;
      gotFCT = 0; gotNChar = 0; TICK_IN = 0; TXWRITE = 0; encAck = 0;
      rxFree = 0; TIME_IN = 0; TXDATA = 0;

      // reset state
      repeat (3) @(negedge CLOCK);
      chk("rst_txrdy", TXRDY, 1);
      chk("rst_valid", charValid, 0);
      chk("rst_type", charType, 0);
      chk("rst_data", charData, 0);
      chk("rst_txcredit", txCredit, 0);
      chk("rst_rxout", rxOutstanding, 0);
      chk("rst_err", creditError, 0);
      @(posedge CLOCK); #1 RESETn = 1'b1;

      // NULL-only slots and ack-to-valid latency
      enableTx = 1; sendNULLs = 1;
      repeat (3) push_exp(T_NULL, 9'h000);
      serve_slot("null0");
      @(negedge CLOCK); chk("lat_cycle1_valid", charValid, 0);
      @(negedge CLOCK); chk("lat_cycle2_valid", charValid, 1);
      chk("null_txcredit", txCredit, 0);
      serve_slot("null1");
      serve_slot("null2");

      // FCTs until the credit ceiling, then NULLs until enough N-Chars have arrived
      reset_tx();
      sendFCTs = 1; rxFree = 6'd63;
      for (int i = 0; i < 7; i++) push_exp(T_FCT, 9'h000);
      for (int i = 0; i < 7; i++) serve_slot("fct_fill");
      chk("fct_rx56", rxOutstanding, 56);
      push_exp(T_NULL, 9'h000);
      serve_slot("fct_full_null0");
      do_gotnchar(1);
      chk("fct_rx55", rxOutstanding, 55);
      push_exp(T_NULL, 9'h000);
      serve_slot("fct_full_null1");
      do_gotnchar(7);
      chk("fct_rx48", rxOutstanding, 48);
      push_exp(T_NULL, 9'h000);
      serve_slot("fct_full_null2");
      push_exp(T_FCT, 9'h000);
      serve_slot("fct_resume");
      chk("fct_rx56b", rxOutstanding, 56);

      // N-Char waits for TX credit
      reset_tx();
      sendNChars = 1; sendTimeCodes = 1; rxFree = 6'd0;
      do_write(9'h041);
      @(negedge CLOCK); chk("nch_txrdy_busy", TXRDY, 0);
      push_exp(T_NULL, 9'h000);
      serve_slot("nch_nocredit");
      do_gotfct();
      chk("nch_tx8", txCredit, 8);
      push_exp(T_NULL, 9'h000);
      serve_slot("nch_presel");
      chk("nch_txrdy_held", TXRDY, 0);
      push_exp(T_NCHAR, 9'h041);
      serve_slot("nch_sent");
      chk("nch_tx7", txCredit, 7);
      chk("nch_txrdy_free", TXRDY, 1);

      // Time-Code overwrite and priority over FCT and N-Char
      @(posedge CLOCK); #1;
      rxFree = 6'd63;
      do_write(9'h1AB);
      do_tick(8'h15);
      do_tick(8'h16);
      push_exp(T_NULL, 9'h000);
      push_exp(T_TC, 9'h016);
      push_exp(T_FCT, 9'h000);
      serve_slot("tc_pre");
      serve_slot("tc_sent");
      serve_slot("tc_then_fct");
      sendFCTs = 0;
      push_exp(T_NCHAR, 9'h1AB);
      serve_slot("tc_nch_ctrl");
      chk("tc_tx6", txCredit, 6);
      chk("tc_rx8", rxOutstanding, 8);

      // credit arithmetic and error pulses, no characters eligible
      reset_tx();
      sendNULLs = 0; sendFCTs = 0; sendNChars = 0; sendTimeCodes = 0;
      @(negedge CLOCK);
      for (int i = 0; i < 13; i++) begin
         gotFCT   = vt[i].gfct;
         gotNChar = vt[i].gnch;
         @(posedge CLOCK); #1;
         gotFCT   = 1'b0;
         gotNChar = 1'b0;
         @(negedge CLOCK);
         chk($sformatf("vec%0d_tx", i), txCredit, vt[i].tx);
         chk($sformatf("vec%0d_rx", i), rxOutstanding, vt[i].rx);
         chk($sformatf("vec%0d_err", i), creditError, vt[i].err);
      end

      // resetTx in the middle of a presented character
      reset_tx();
      sendNULLs = 1; sendFCTs = 1; rxFree = 6'd63;
      do_tick(8'h2A);
      do_gotfct();
      push_exp(T_FCT, 9'h000);
      serve_slot("clr_pre");
      do_write(9'h055);
      wait_valid("clr_present");
      chk("clr_pre_tx", txCredit, 8);
      chk("clr_pre_rx", rxOutstanding, 8);
      reset_tx();
      @(negedge CLOCK);
      chk("clr_valid", charValid, 0);
      chk("clr_tx", txCredit, 0);
      chk("clr_rx", rxOutstanding, 0);
      chk("clr_txrdy", TXRDY, 1);
      sendTimeCodes = 1;
      push_exp(T_FCT, 9'h000);
      serve_slot("clr_no_tick");

      // enableTx low keeps a pending Time-Code
      sendTimeCodes = 0;
      do_tick(8'h33);
      enableTx = 0;
      @(posedge CLOCK); #1 enableTx = 1;
      @(negedge CLOCK); chk("dis_valid", charValid, 0);
      sendTimeCodes = 1;
      push_exp(T_TC, 9'h033);
      serve_slot("dis_tick_kept");

      chk("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
